mem_line_reader: RTL

- Initiator for the 16-byte memory request/response val/rdy protocol.
- Accepts a command of base address plus line count and issues sequential 16B READ requests.
- Collects responses in order and streams the 128-bit lines to a consumer with a last flag.
- Sits between accelerator/test logic and any 16B memory responder, e.g. the single-port RAM wrapper used in benches.

---
 rtl/mem_line_reader_pkg.sv | 13 +
 rtl/vc_mem_msgs.sv | 26 ++
 rtl/mem_line_fifo.sv | 49 ++++
 rtl/mem_line_reader.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mem_line_reader_pkg.sv
// Shared state encoding and address helper for the line reader.
package mem_line_reader_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int LINE_BYTES = 16;

  // Byte address of line idx relative to a line-aligned base; wraps mod 2^32.
  function automatic logic [31:0] line_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + idx * 32'(LINE_BYTES);
  endfunction

endpackage

// File: rtl/vc_mem_msgs.sv
// Shared 16-byte memory request/response message formats used by all
// initiators and responders on the val/rdy memory interface.
package vc_mem_msgs;

  localparam logic [3:0] MEM_TYPE_READ  = 4'd0;
  localparam logic [3:0] MEM_TYPE_WRITE = 4'd1;
  localparam logic [3:0] MEM_TYPE_INIT  = 4'd2;

  // len=0 encodes a full 16-byte access.
  typedef struct packed {
    logic [3:0]   type_;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [3:0]   type_;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;

endpackage

// File: rtl/mem_line_fifo.sv
// Synchronous FIFO holding returned lines plus their last-line marker.
module mem_line_fifo #(
  parameter int W     = 129,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_line_reader.sv
// Reads a run of sequential 16B lines from a val/rdy memory and streams them
// out in order, using a credit limit so returned lines always have space.
module mem_line_reader
  import vc_mem_msgs::*;
  import mem_line_reader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_val,
  output logic               cmd_rdy,
  input  logic [31:0]        cmd_addr,
  input  logic [CNT_W-1:0]   cmd_lines,
  output mem_req_16B_t       memreq_msg,
  output logic               memreq_val,
  input  logic               memreq_rdy,
  input  mem_resp_16B_t      memresp_msg,
  input  logic               memresp_val,
  output logic               memresp_rdy,
  output logic [127:0]       out_data,
  output logic               out_val,
  input  logic               out_rdy,
  output logic               out_last,
  output logic               busy,
  output logic               err
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Valid/ready: a transfer happens on a rising edge where val && rdy; every
  // valid here is derived from registered state only, never from a ready.
  state_t           state;
  logic [31:0]      base;
  logic [CNT_W-1:0] lines;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] received;
  logic [CNT_W-1:0] delivered;
  logic [CNT_W-1:0] inflight;
  logic [CW-1:0]    fifo_count;
  logic [128:0]     fifo_head;
  logic [128:0]     push_data;
  logic             cmd_fire;
  logic             req_fire;
  logic             resp_ok;
  logic             push;
  logic             out_fire;
  logic             unused;

  assign inflight    = issued - delivered;
  assign cmd_rdy     = (state == IDLE);
  assign busy        = (state == RUN);
  assign memresp_rdy = 1'b1;
  assign memreq_val  = (state == RUN) && (issued < lines) && (inflight < CNT_W'(DEPTH));

  assign cmd_fire = cmd_val && cmd_rdy;
  assign req_fire = memreq_val && memreq_rdy;
  assign resp_ok  = (state == RUN) && (received < lines);
  assign push     = memresp_val && resp_ok;
  assign out_fire = out_val && out_rdy;

  assign push_data = {received == (lines - CNT_W'(1)), memresp_msg.data};
  assign out_val   = (fifo_count != '0);
  assign out_data  = fifo_head[127:0];
  assign out_last  = out_val && fifo_head[128];

  assign unused = ^{cmd_addr[3:0], memresp_msg.opaque, memresp_msg.test, memresp_msg.len};

  // Message depends only on issued, so it holds steady through a stall.
  always_comb begin
    memreq_msg        = '0;
    memreq_msg.type_  = MEM_TYPE_READ;
    memreq_msg.opaque = issued[7:0];
    memreq_msg.addr   = line_addr(base, 32'(issued));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base      <= '0;
      lines     <= '0;
      issued    <= '0;
      received  <= '0;
      delivered <= '0;
      err       <= 1'b0;
    end else begin
      if (req_fire) issued    <= issued + CNT_W'(1);
      if (push)     received  <= received + CNT_W'(1);
      if (out_fire) delivered <= delivered + CNT_W'(1);
      case (state)
        IDLE: begin
          if (cmd_fire && (cmd_lines != '0)) begin
            base      <= {cmd_addr[31:4], 4'b0};
            lines     <= cmd_lines;
            issued    <= '0;
            received  <= '0;
            delivered <= '0;
            err       <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (out_fire && out_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A bad or unsolicited response outranks the clear on command accept.
      if (memresp_val && (!resp_ok || (memresp_msg.type_ != MEM_TYPE_READ))) err <= 1'b1;
    end
  end

  mem_line_fifo #(
    .W     (129),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (out_fire),
    .head      (fifo_head),
    .count     (fifo_count)
  );

endmodule
